// File: rtl/rect_pkg.sv
// Shared types and default geometry for the rectangle draw controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rect_pkg;

    localparam int RECT_X_W      = 8;
    localparam int RECT_Y_W      = 7;
    localparam int RECT_SZ_W     = 4;
    localparam int RECT_SCREEN_W = 160;
    localparam int RECT_SCREEN_H = 120;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        DRAW,
        DONE
    } rect_state_e;

    typedef logic [RECT_X_W-1:0]  pix_x_t;
    typedef logic [RECT_Y_W-1:0]  pix_y_t;
    typedef logic [RECT_SZ_W-1:0] rect_sz_t;

endpackage

// File: rtl/rect_sweep_counter.sv
// Row-major dx/dy sweep over a w x h grid (dx inner, dy outer).
// Latency: dx/dy/last reflect the current pixel; one step per enabled cycle.
// Backpressure: none; advances only while i_en is high, i_clr returns to (0,0).
module rect_sweep_counter
    import rect_pkg::*;
#(
    parameter int SZ_W = RECT_SZ_W
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [SZ_W-1:0] i_w,
    input  logic [SZ_W-1:0] i_h,
    output logic [SZ_W-1:0] o_dx,
    output logic [SZ_W-1:0] o_dy,
    output logic            o_last
);

    localparam logic [SZ_W-1:0] LP_ONE = {{(SZ_W-1){1'b0}}, 1'b1};

    logic [SZ_W-1:0] r_dx;
    logic [SZ_W-1:0] r_dy;
    logic            w_row_end;

    assign w_row_end = (r_dx == (i_w - LP_ONE));
    assign o_last    = w_row_end && (r_dy == (i_h - LP_ONE));
    assign o_dx      = r_dx;
    assign o_dy      = r_dy;

    // Step to the next pixel; wrap dx at the row end and move down one row.
    always_ff @(posedge clk) begin
        if (!resetn || i_clr) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_en) begin
            if (w_row_end) begin
                r_dx <= '0;
                r_dy <= r_dy + LP_ONE;
            end else begin
                r_dx <= r_dx + LP_ONE;
            end
        end
    end

endmodule

// File: rtl/rect_draw_ctrl.sv
// Rectangle draw sequencer: one command in, one clipped pixel + plot strobe per cycle out (RECT_OUTLINE_EN adds cmd_fill/outline mode).
// Latency: handshake at edge N -> first plot after N+3, done pulse after N+3+w*h.
// Backpressure: cmd_ready only in IDLE; abort cancels an in-flight rectangle without done.
module rect_draw_ctrl
    import rect_pkg::*;
#(
    parameter int X_W      = RECT_X_W,
    parameter int Y_W      = RECT_Y_W,
    parameter int SZ_W     = RECT_SZ_W,
    parameter int SCREEN_W = RECT_SCREEN_W,
    parameter int SCREEN_H = RECT_SCREEN_H
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [X_W-1:0]  cmd_x,
    input  logic [Y_W-1:0]  cmd_y,
    input  logic [SZ_W-1:0] cmd_w,
    input  logic [SZ_W-1:0] cmd_h,
    input  logic [2:0]      cmd_colour,
`ifdef RECT_OUTLINE_EN
    input  logic            cmd_fill,
`endif
    input  logic            abort,
    output logic [X_W-1:0]  vga_x,
    output logic [Y_W-1:0]  vga_y,
    output logic [2:0]      vga_colour,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    // Screen limits at the unwrapped sum width so off-screen carries still clip.
    localparam logic [X_W:0] LP_SCR_W = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] LP_SCR_H = SCREEN_H[Y_W:0];

    rect_state_e     r_state;
    logic [X_W-1:0]  r_sh_x;
    logic [Y_W-1:0]  r_sh_y;
    logic [X_W-1:0]  r_base_x;
    logic [Y_W-1:0]  r_base_y;
    logic [SZ_W-1:0] r_w;
    logic [SZ_W-1:0] r_h;
    logic [2:0]      r_colour;
    logic [X_W-1:0]  r_vga_x;
    logic [Y_W-1:0]  r_vga_y;
    logic            r_plot;
    logic            r_done;

    logic [SZ_W-1:0] w_dx;
    logic [SZ_W-1:0] w_dy;
    logic            w_last;
    logic [X_W:0]    w_sum_x;
    logic [Y_W:0]    w_sum_y;
    logic            w_clip;
    logic            w_shape;
    logic            w_cnt_clr;
    logic            w_cnt_en;

    rect_sweep_counter #(
        .SZ_W (SZ_W)
    ) u_sweep (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .i_w    (r_w),
        .i_h    (r_h),
        .o_dx   (w_dx),
        .o_dy   (w_dy),
        .o_last (w_last)
    );

    // The counter is parked at (0,0) while entering DRAW and frozen on abort.
    assign w_cnt_clr = (r_state == LOAD_Y);
    assign w_cnt_en  = (r_state == DRAW) && !abort;

    assign w_sum_x = {1'b0, r_base_x} + {{(X_W+1-SZ_W){1'b0}}, w_dx};
    assign w_sum_y = {1'b0, r_base_y} + {{(Y_W+1-SZ_W){1'b0}}, w_dy};
    assign w_clip  = (w_sum_x >= LP_SCR_W) || (w_sum_y >= LP_SCR_H);

`ifdef RECT_OUTLINE_EN
    localparam logic [SZ_W-1:0] LP_ONE = {{(SZ_W-1){1'b0}}, 1'b1};
    logic r_fill;
    logic w_border;
    assign w_border = (w_dx == '0) || (w_dx == (r_w - LP_ONE)) ||
                      (w_dy == '0) || (w_dy == (r_h - LP_ONE));
    assign w_shape  = r_fill || w_border;
`else
    assign w_shape  = 1'b1;
`endif

    assign cmd_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_colour;
    assign plot       = r_plot;
    assign done       = r_done;

    // Command FSM with registered pixel, plot and done outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_sh_x   <= '0;
            r_sh_y   <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_colour <= '0;
            r_vga_x  <= '0;
            r_vga_y  <= '0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
`ifdef RECT_OUTLINE_EN
            r_fill   <= 1'b1;
`endif
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_sh_x   <= cmd_x;
                        r_sh_y   <= cmd_y;
                        r_w      <= cmd_w;
                        r_h      <= cmd_h;
                        r_colour <= cmd_colour;
`ifdef RECT_OUTLINE_EN
                        r_fill   <= cmd_fill;
`endif
                        r_state  <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_base_x <= r_sh_x;
                        r_state  <= LOAD_Y;
                    end
                end
                LOAD_Y: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_base_y <= r_sh_y;
                        // Degenerate rectangles skip DRAW but still report done.
                        if ((r_w == '0) || (r_h == '0)) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        // Coordinates wrap at port width; clipped pixels still take a cycle.
                        r_vga_x <= w_sum_x[X_W-1:0];
                        r_vga_y <= w_sum_y[Y_W-1:0];
                        r_plot  <= !w_clip && w_shape;
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
